// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback control: result selection,
// r0 write suppression, sticky halt and a saturating retire counter.
module wb_stage #(
    parameter int DATA_WIDTH     = 16,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mem_valid,
    input  logic                      mem_RegWrite,
    input  logic [REG_ADDR_WIDTH-1:0] mem_DstReg,
    input  logic [1:0]                mem_WbSel,
    input  logic [DATA_WIDTH-1:0]     mem_AluResult,
    input  logic [DATA_WIDTH-1:0]     mem_LoadData,
    input  logic [DATA_WIDTH-1:0]     mem_PcPlus2,
    input  logic                      mem_Halt,
    input  logic                      stall,
    input  logic                      flush,
    output logic [REG_ADDR_WIDTH-1:0] DstReg,
    output logic                      WriteReg,
    output logic [DATA_WIDTH-1:0]     DstData,
    output logic                      wb_valid,
    output logic                      Halted,
    output logic [COUNT_WIDTH-1:0]    RetireCount
);

    typedef enum logic {
        RUN,
        HALT
    } state_t;

    state_t                    state;
    state_t                    state_next;
    logic                      wb_RegWrite;
    logic                      wb_Halt;
    logic                      halting;
    logic                      bubble;
    logic [DATA_WIDTH-1:0]     sel_data;

    assign Halted = (state == HALT);

    // The edge that retires HLT must already refuse the next instruction,
    // so the sticky flag is anticipated rather than waited for.
    assign halting = Halted | (wb_valid & wb_Halt);
    assign bubble  = halting | flush | stall;

    // Result source select; code 3 is reserved and falls back to the ALU.
    always_comb begin
        sel_data = mem_AluResult;
        case (mem_WbSel)
            2'd1:    sel_data = mem_LoadData;
            2'd2:    sel_data = mem_PcPlus2;
            default: sel_data = mem_AluResult;
        endcase
    end

    // Halt state transition: leave RUN once HLT sits in WB.
    always_comb begin
        state_next = state;
        if (state == RUN && wb_valid && wb_Halt)
            state_next = HALT;
    end

    // Halt state register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= RUN;
        else
            state <= state_next;
    end

    // MEM/WB capture: bubbles clear control, data fields keep stale values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid    <= 1'b0;
            wb_RegWrite <= 1'b0;
            wb_Halt     <= 1'b0;
            DstReg      <= '0;
            DstData     <= '0;
        end else if (bubble) begin
            wb_valid    <= 1'b0;
            wb_RegWrite <= 1'b0;
            wb_Halt     <= 1'b0;
        end else begin
            wb_valid    <= mem_valid;
            wb_RegWrite <= mem_RegWrite;
            wb_Halt     <= mem_Halt;
            DstReg      <= mem_DstReg;
            DstData     <= sel_data;
        end
    end

    // Retired-instruction counter, saturating and frozen after halt.
    always_ff @(posedge clk) begin
        if (rst)
            RetireCount <= '0;
        else if (!Halted && wb_valid && RetireCount != '1)
            RetireCount <= RetireCount + 1'b1;
    end

    assign WriteReg = wb_valid & wb_RegWrite & ~wb_Halt &
                      (DstReg != '0) & ~Halted;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: table of single-edge vectors plus
// hand-written halt, reset-recovery and counter-saturation sequences.
module tb_wb_stage;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_valid;
    logic          mem_RegWrite;
    logic [AW-1:0] mem_DstReg;
    logic [1:0]    mem_WbSel;
    logic [DW-1:0] mem_AluResult;
    logic [DW-1:0] mem_LoadData;
    logic [DW-1:0] mem_PcPlus2;
    logic          mem_Halt;
    logic          stall;
    logic          flush;
    logic [AW-1:0] DstReg;
    logic          WriteReg;
    logic [DW-1:0] DstData;
    logic          wb_valid;
    logic          Halted;
    logic [CW-1:0] RetireCount;

    int errors = 0;
    int checks = 0;

    wb_stage #(
        .DATA_WIDTH    (DW),
        .REG_ADDR_WIDTH(AW),
        .COUNT_WIDTH   (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_valid    (mem_valid),
        .mem_RegWrite (mem_RegWrite),
        .mem_DstReg   (mem_DstReg),
        .mem_WbSel    (mem_WbSel),
        .mem_AluResult(mem_AluResult),
        .mem_LoadData (mem_LoadData),
        .mem_PcPlus2  (mem_PcPlus2),
        .mem_Halt     (mem_Halt),
        .stall        (stall),
        .flush        (flush),
        .DstReg       (DstReg),
        .WriteReg     (WriteReg),
        .DstData      (DstData),
        .wb_valid     (wb_valid),
        .Halted       (Halted),
        .RetireCount  (RetireCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          v;
        logic          rw;
        logic [AW-1:0] dst;
        logic [1:0]    sel;
        logic [DW-1:0] alu;
        logic [DW-1:0] ld;
        logic [DW-1:0] pc;
        logic          hlt;
        logic          stl;
        logic          fl;
        logic          e_wr;
        logic          e_valid;
        logic [AW-1:0] e_dst;
        logic [DW-1:0] e_data;
        logic [CW-1:0] e_cnt;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rw, input logic [AW-1:0] dst,
                         input logic [1:0] sel, input logic [DW-1:0] alu,
                         input logic [DW-1:0] ld, input logic [DW-1:0] pc,
                         input logic hlt, input logic stl, input logic fl);
        mem_valid     = v;
        mem_RegWrite  = rw;
        mem_DstReg    = dst;
        mem_WbSel     = sel;
        mem_AluResult = alu;
        mem_LoadData  = ld;
        mem_PcPlus2   = pc;
        mem_Halt      = hlt;
        stall         = stl;
        flush         = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //             v   rw  dst   sel  alu       ld        pc        h   s   f    wr  vld dst   data      cnt
        vecs[0]  = '{1'b0,1'b0,4'd0,2'd0,16'h0000,16'h0000,16'h0000,1'b0,1'b0,1'b0, 1'b0,1'b0,4'd0,16'h0000,3'd0};
        vecs[1]  = '{1'b0,1'b0,4'd0,2'd0,16'h0000,16'h0000,16'h0000,1'b0,1'b0,1'b0, 1'b0,1'b0,4'd0,16'h0000,3'd0};
        vecs[2]  = '{1'b0,1'b0,4'd0,2'd0,16'h0000,16'h0000,16'h0000,1'b0,1'b0,1'b0, 1'b0,1'b0,4'd0,16'h0000,3'd0};
        vecs[3]  = '{1'b1,1'b1,4'd5,2'd0,16'h1234,16'h0000,16'h0000,1'b0,1'b0,1'b0, 1'b1,1'b1,4'd5,16'h1234,3'd0};
        vecs[4]  = '{1'b1,1'b1,4'd3,2'd1,16'h1111,16'hBEEF,16'h2222,1'b0,1'b0,1'b0, 1'b1,1'b1,4'd3,16'hBEEF,3'd1};
        vecs[5]  = '{1'b1,1'b1,4'd7,2'd2,16'h3333,16'h4444,16'h0042,1'b0,1'b0,1'b0, 1'b1,1'b1,4'd7,16'h0042,3'd2};
        vecs[6]  = '{1'b1,1'b1,4'd0,2'd0,16'hFFFF,16'h0000,16'h0000,1'b0,1'b0,1'b0, 1'b0,1'b1,4'd0,16'hFFFF,3'd3};
        vecs[7]  = '{1'b1,1'b1,4'd4,2'd0,16'h4444,16'h0000,16'h0000,1'b0,1'b1,1'b0, 1'b0,1'b0,4'd0,16'h0000,3'd4};
        vecs[8]  = '{1'b1,1'b1,4'd4,2'd0,16'h4444,16'h0000,16'h0000,1'b0,1'b0,1'b1, 1'b0,1'b0,4'd0,16'h0000,3'd4};
        vecs[9]  = '{1'b1,1'b1,4'd4,2'd0,16'h4444,16'h0000,16'h0000,1'b0,1'b1,1'b1, 1'b0,1'b0,4'd0,16'h0000,3'd4};
        vecs[10] = '{1'b0,1'b1,4'd6,2'd0,16'h5555,16'h0000,16'h0000,1'b0,1'b0,1'b0, 1'b0,1'b0,4'd0,16'h0000,3'd4};
        vecs[11] = '{1'b1,1'b1,4'd9,2'd3,16'h0A0A,16'hDEAD,16'hCAFE,1'b0,1'b0,1'b0, 1'b1,1'b1,4'd9,16'h0A0A,3'd4};
        vecs[12] = '{1'b1,1'b0,4'd8,2'd0,16'h1111,16'h0000,16'h0000,1'b0,1'b0,1'b0, 1'b0,1'b1,4'd8,16'h1111,3'd5};
        vecs[13] = '{1'b0,1'b0,4'd0,2'd0,16'h0000,16'h0000,16'h0000,1'b0,1'b0,1'b0, 1'b0,1'b0,4'd0,16'h0000,3'd6};

        // Reset
        rst = 1'b1;
        drive(1'b1, 1'b1, 4'd5, 2'd0, 16'h9999, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        tick();
        check("rst_WriteReg", WriteReg, 0);
        check("rst_DstReg", DstReg, 0);
        check("rst_DstData", DstData, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_Halted", Halted, 0);
        check("rst_RetireCount", RetireCount, 0);
        rst = 1'b0;

        // Table of single-edge vectors
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].v, vecs[i].rw, vecs[i].dst, vecs[i].sel, vecs[i].alu,
                  vecs[i].ld, vecs[i].pc, vecs[i].hlt, vecs[i].stl, vecs[i].fl);
            tick();
            check($sformatf("v%0d_WriteReg", i), WriteReg, vecs[i].e_wr);
            check($sformatf("v%0d_wb_valid", i), wb_valid, vecs[i].e_valid);
            check($sformatf("v%0d_RetireCount", i), RetireCount, vecs[i].e_cnt);
            check($sformatf("v%0d_Halted", i), Halted, 0);
            if (vecs[i].e_valid) begin
                check($sformatf("v%0d_DstReg", i), DstReg, vecs[i].e_dst);
                check($sformatf("v%0d_DstData", i), DstData, vecs[i].e_data);
            end
        end

        // HLT (with RegWrite set, must not write) then a write to r2
        drive(1'b1, 1'b1, 4'd1, 2'd0, 16'h7777, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
        tick();
        check("hlt_in_wb_valid", wb_valid, 1);
        check("hlt_in_wb_WriteReg", WriteReg, 0);
        check("hlt_in_wb_Halted", Halted, 0);
        check("hlt_in_wb_cnt", RetireCount, 6);
        drive(1'b1, 1'b1, 4'd2, 2'd0, 16'h0001, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("halted%0d_Halted", k), Halted, 1);
            check($sformatf("halted%0d_wb_valid", k), wb_valid, 0);
            check($sformatf("halted%0d_WriteReg", k), WriteReg, 0);
            check($sformatf("halted%0d_cnt", k), RetireCount, 7);
        end

        // Reset out of halt
        rst = 1'b1;
        tick();
        check("rst2_Halted", Halted, 0);
        check("rst2_cnt", RetireCount, 0);
        check("rst2_wb_valid", wb_valid, 0);
        check("rst2_WriteReg", WriteReg, 0);
        rst = 1'b0;
        tick();
        check("resume_WriteReg", WriteReg, 1);
        check("resume_DstReg", DstReg, 2);
        check("resume_DstData", DstData, 16'h0001);

        // Counter saturation at all-ones (3-bit counter here)
        drive(1'b1, 1'b1, 4'd2, 2'd0, 16'h0001, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) tick();
        check("sat_cnt", RetireCount, 7);
        tick();
        check("sat_hold_cnt", RetireCount, 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
MEM/WB pipeline register and writeback control for the 16-bit 5-stage core. It is the writer side of the register file write port: it captures the retiring instruction from MEM and selects the result source. It drives DstReg/WriteReg/DstData into the register file. It also owns r0 write suppression, HLT detection (sticky halt) and a retired-instruction counter.

Parameters:
DATA_WIDTH, 16, width of register data and result buses
REG_ADDR_WIDTH, 4, register index width (16 registers)
COUNT_WIDTH, 16, width of retired-instruction counter

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous reset, active-high
mem_valid  input  1  MEM stage holds a real instruction
mem_RegWrite  input  1  instruction writes a register
mem_DstReg  input  REG_ADDR_WIDTH  destination register index
mem_WbSel  input  2  result select: 0 ALU, 1 load data, 2 PC+2, 3 reserved (treated as ALU)
mem_AluResult  input  DATA_WIDTH  ALU result
mem_LoadData  input  DATA_WIDTH  data-memory read data
mem_PcPlus2  input  DATA_WIDTH  PC+2 of instruction (PCS)
mem_Halt  input  1  instruction is HLT
stall  input  1  MEM held this cycle; WB receives bubble
flush  input  1  squash instruction entering WB
DstReg  output  REG_ADDR_WIDTH  register file write index
WriteReg  output  1  register file write enable
DstData  output  DATA_WIDTH  register file write data
wb_valid  output  1  WB holds a real instruction this cycle
Halted  output  1  sticky: HLT has retired
RetireCount  output  COUNT_WIDTH  instructions retired since reset

Behaviour:
- Reset (rst=1 at posedge): wb_valid=0, Halted=0, RetireCount=0, internal DstReg/RegWrite/WbSel/Halt/data fields=0. Outputs after reset: WriteReg=0, DstReg=0, DstData=0.
- Capture priority at each posedge (not rst), highest first:
  - Halted=1 → load bubble (valid=0).
  - flush → bubble.
  - stall → bubble.
  - otherwise capture mem_valid and all mem_* fields.
  - Bubbles clear the RegWrite and Halt fields. Data fields may hold stale values.
- Result mux: the selected value is registered at capture. DstData is a direct register output with no combinational path from mem_* to DstData.
- WriteReg is combinational from WB state: wb_valid & wb_RegWrite & ~wb_Halt & (DstReg != 0) & ~Halted.
  - r0 writes are never issued.
  - DstReg and DstData are driven from WB state even when WriteReg=0.
- Latency: an instruction presented in MEM with stall=flush=0 at edge N is in WB during cycle N..N+1. Its register write commits at edge N+1.
- Each instruction is in WB for exactly one cycle. No write is ever repeated.
- Halt: at a posedge where wb_valid & wb_Halt, Halted<=1.
  - Halted then stays 1 until rst.
  - No instruction after HLT enters WB or writes.
  - The HLT instruction itself counts as retired.
- RetireCount: at each posedge (not rst, Halted=0), add wb_valid. Saturates at all-ones with no wrap. Frozen once Halted=1.
- Simultaneous events:
  - flush and stall together → bubble.
  - rst wins over everything.
  - rst mid-halt clears Halted and the counter; capture resumes at the next edge.
- mem_valid=0 with RegWrite=1 must produce no write. valid gates everything.

Test Plan:
- Reset then 3 idle cycles → WriteReg=0, wb_valid=0, Halted=0, RetireCount=0.
- mem_valid=1, RegWrite=1, DstReg=5, WbSel=0, AluResult=0x1234 → next cycle WriteReg=1, DstReg=5, DstData=0x1234 for exactly one cycle; RetireCount=1 after the following edge.
- Back-to-back: WbSel=1 with LoadData=0xBEEF to r3, then WbSel=2 with PcPlus2=0x0042 to r7 → consecutive cycles write r3=0xBEEF, then r7=0x0042; RetireCount=2.
- DstReg=0, RegWrite=1, AluResult=0xFFFF → WriteReg=0, wb_valid=1, RetireCount increments.
- Instruction to r4 with stall=1, then with flush=1 → wb_valid=0 and WriteReg=0 both cycles; RetireCount unchanged.
- HLT followed by a valid write to r2=0x0001 → Halted=1 one edge after HLT is in WB; r2 is never written; RetireCount stays frozen. Assert rst → Halted=0, RetireCount=0.
